// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths and ALU opcode encodings for the risc_datapath slice.
package datapath_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_NEG  = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd11;
  localparam logic [4:0] OP_INC  = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational 64-bit-result ALU (A = Y, B = bus).
// Signed MUL/DIV exist only when DATAPATH_MULDIV_EN is defined; otherwise those opcodes give 0.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          op,
  output logic [2*DATA_W-1:0] result
);
  logic [4:0]          sh;
  logic [2*DATA_W-1:0] ror_w, rol_w;
  logic [DATA_W-1:0]   sra;
  assign sh    = b[4:0];
  // Rotates come from shifting a doubled copy of A and keeping the wrapped half.
  assign ror_w = {a, a} >> sh;
  assign rol_w = {a, a} << sh;
  assign sra   = $signed(a) >>> sh;
`ifdef DATAPATH_MULDIV_EN
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          quo, rem;
  assign prod = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
  assign quo  = (b == '0) ? '1 : DATA_W'($signed(a) / $signed(b));
  assign rem  = (b == '0) ? a  : DATA_W'($signed(a) % $signed(b));
`endif
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result[DATA_W-1:0] = a + b;
      OP_SUB:  result[DATA_W-1:0] = a - b;
      OP_AND:  result[DATA_W-1:0] = a & b;
      OP_OR:   result[DATA_W-1:0] = a | b;
      OP_NEG:  result[DATA_W-1:0] = -b;
      OP_NOT:  result[DATA_W-1:0] = ~b;
      OP_SHR:  result[DATA_W-1:0] = a >> sh;
      OP_SHRA: result[DATA_W-1:0] = sra;
      OP_SHL:  result[DATA_W-1:0] = a << sh;
      OP_ROR:  result[DATA_W-1:0] = ror_w[DATA_W-1:0];
      OP_ROL:  result[DATA_W-1:0] = rol_w[2*DATA_W-1:DATA_W];
      OP_INC:  result[DATA_W-1:0] = b + DATA_W'(1);
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  result = prod;
      OP_DIV:  result = {rem, quo};
`endif
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/risc_datapath.sv
// risc_datapath: 32-bit single-bus CPU datapath driven by one-hot control strobes.
// Optional signed MUL/DIV in the ALU is enabled by defining DATAPATH_MULDIV_EN.
module risc_datapath
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic              R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic              PCin, IRin, Yin, MARin, MDRin, HIin, LOin, Zin,
  input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic              HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
  input  logic              Read,
  input  logic [4:0]        OpCode,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] BusMuxOut,
  output logic [DATA_W-1:0] MAR_q,
  output logic [DATA_W-1:0] IR_q
);
  logic [NUM_REGS-1:0] rin, rout;
  logic [DATA_W-1:0]   r [NUM_REGS];
  logic [DATA_W-1:0]   hi, lo, pc, y, mdr, bus;
  logic [2*DATA_W-1:0] z, alu_res;
  assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  // Later assignments override earlier ones, so sources are listed lowest priority first.
  always_comb begin
    bus = '0;
    if (MDRout) bus = mdr;
    if (PCout) bus = pc;
    if (Zlowout) bus = z[DATA_W-1:0];
    if (Zhighout) bus = z[2*DATA_W-1:DATA_W];
    if (LOout) bus = lo;
    if (HIout) bus = hi;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (rout[i]) bus = r[i];
  end
  assign BusMuxOut = bus;
  datapath_alu u_alu (
    .a(y),
    .b(bus),
    .op(OpCode),
    .result(alu_res)
  );
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
      hi    <= '0;
      lo    <= '0;
      pc    <= '0;
      y     <= '0;
      mdr   <= '0;
      z     <= '0;
      MAR_q <= '0;
      IR_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (rin[i]) r[i] <= bus;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (PCin) pc <= bus;
      if (Yin) y <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (Zin) z <= alu_res;
      if (MARin) MAR_q <= bus;
      if (IRin) IR_q <= bus;
    end
  end
endmodule

// File: tb/tb_risc_datapath.sv
// tb_risc_datapath: directed plus randomized checks of risc_datapath against a behavioural model.
module tb_risc_datapath;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] rin, rout;
  logic        pcin, irin, yin, marin, mdrin, hiin, loin, zin;
  logic        hiout, loout, zhout, zlout, pcout, mdrout, read;
  logic [4:0]  opc;
  logic [31:0] mdat, bus_q, mar_q, ir_q;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr;
  logic [63:0] m_z;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk(clk), .clr(clr),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(pcin), .IRin(irin), .Yin(yin), .MARin(marin), .MDRin(mdrin),
    .HIin(hiin), .LOin(loin), .Zin(zin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(hiout), .LOout(loout), .Zhighout(zhout), .Zlowout(zlout),
    .PCout(pcout), .MDRout(mdrout), .Read(read), .OpCode(opc), .Mdatain(mdat),
    .BusMuxOut(bus_q), .MAR_q(mar_q), .IR_q(ir_q)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    rin = '0; rout = '0;
    {pcin, irin, yin, marin, mdrin, hiin, loin, zin} = '0;
    {hiout, loout, zhout, zlout, pcout, mdrout, read} = '0;
    opc = '0; mdat = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr} = '0;
    m_z = '0;
  endtask

  // Bus = value of the first asserted source in priority order, else 0.
  function automatic logic [31:0] model_bus();
    logic [31:0] v [22];
    logic [21:0] s;
    logic [31:0] res;
    bit found;
    for (int i = 0; i < 16; i++) v[i] = m_r[i];
    v[16] = m_hi; v[17] = m_lo; v[18] = m_z[63:32]; v[19] = m_z[31:0];
    v[20] = m_pc; v[21] = m_mdr;
    s = {mdrout, pcout, zlout, zhout, loout, hiout, rout};
    res = '0;
    found = 0;
    for (int i = 0; i < 22; i++)
      if (s[i] && !found) begin
        found = 1;
        res = v[i];
      end
    return res;
  endfunction

  // Arithmetic reference: shifts as powers of two, rotates one bit at a time.
  function automatic logic [63:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint mask, ua, ub, sa, sb, pw, q, rm;
    logic [31:0] t;
    int sh;
    mask = 64'hFFFF_FFFF;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    pw = longint'(64'd1 << sh);
    t = a;
    case (op)
      5'd0:  return (ua + ub) & mask;
      5'd1:  return (ua - ub) & mask;
      5'd2:  return ua & ub;
      5'd3:  return ua | ub;
      5'd4:  return (0 - ub) & mask;
      5'd5:  return mask ^ ub;
      5'd6:  return ua / pw;
      5'd7:  return ((sa < 0) ? -((-sa + pw - 1) / pw) : sa / pw) & mask;
      5'd8:  return (ua * pw) & mask;
      5'd9: begin
        for (int i = 0; i < sh; i++) t = (t >> 1) | (t << 31);
        return {32'b0, t};
      end
      5'd10: begin
        for (int i = 0; i < sh; i++) t = (t << 1) | (t >> 31);
        return {32'b0, t};
      end
      5'd12: return (ub + 1) & mask;
`ifdef DATAPATH_MULDIV_EN
      5'd11: return sa * sb;
      5'd13: begin
        if (sb == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
`endif
      default: return 64'd0;
    endcase
  endfunction

  // One clock: check the bus before the edge, then update the model from pre-edge values.
  task automatic tick();
    logic [31:0] b;
    logic [63:0] res;
    #1;
    b = model_bus();
    res = ref_alu(opc, m_y, b);
    check("bus", {32'b0, bus_q}, {32'b0, b});
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = b;
    if (hiin) m_hi = b;
    if (loin) m_lo = b;
    if (pcin) m_pc = b;
    if (yin) m_y = b;
    if (irin) m_ir = b;
    if (marin) m_mar = b;
    if (mdrin) m_mdr = read ? mdat : b;
    if (zin) m_z = res;
    check("mar", {32'b0, mar_q}, {32'b0, m_mar});
    check("ir", {32'b0, ir_q}, {32'b0, m_ir});
    clear_ctl();
  endtask

  task automatic set_out(int src);
    if (src < 16) rout[src] = 1'b1;
    else if (src == 16) hiout = 1'b1;
    else if (src == 17) loout = 1'b1;
    else if (src == 18) zhout = 1'b1;
    else if (src == 19) zlout = 1'b1;
    else if (src == 20) pcout = 1'b1;
    else mdrout = 1'b1;
  endtask

  task automatic peek(int src);
    @(negedge clk);
    clear_ctl();
    set_out(src);
    #1;
    check($sformatf("src%0d", src), {32'b0, bus_q}, {32'b0, model_bus()});
    clear_ctl();
  endtask

  task automatic peek_exp(int src, logic [31:0] exp, string tag);
    @(negedge clk);
    clear_ctl();
    set_out(src);
    #1;
    check(tag, {32'b0, bus_q}, {32'b0, exp});
    clear_ctl();
  endtask

  task automatic read_all();
    for (int i = 0; i < 22; i++) peek(i);
  endtask

  task automatic load_mdr(logic [31:0] v);
    read = 1; mdrin = 1; mdat = v;
    tick();
  endtask

  task automatic load_y(logic [31:0] v);
    load_mdr(v);
    mdrout = 1; yin = 1;
    tick();
  endtask

  task automatic alu_mdr(logic [4:0] op, logic [31:0] v);
    load_mdr(v);
    mdrout = 1; opc = op; zin = 1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ctl();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mar", {32'b0, mar_q}, 64'd0);
    check("rst_ir", {32'b0, ir_q}, 64'd0);
    clr = 0;
    read_all();
    // Register load through MDR.
    load_mdr(32'd57);
    mdrout = 1; rin[1] = 1;
    #1;
    check("ld_bus57", {32'b0, bus_q}, 64'd57);
    tick();
    peek_exp(1, 32'd57, "ld_r1");
    // NEG of R1 into Z, then Zlow into R0.
    rout[1] = 1; opc = 5'd4; zin = 1;
    tick();
    peek_exp(19, 32'hFFFF_FFC7, "neg_zlo");
    peek_exp(18, 32'h0, "neg_zhi");
    zlout = 1; rin[0] = 1;
    tick();
    peek_exp(0, 32'hFFFF_FFC7, "neg_r0");
    // Instruction fetch sequence.
    pcout = 1; marin = 1; zin = 1; opc = 5'd12;
    tick();
    check("fetch_mar", {32'b0, mar_q}, 64'd0);
    peek_exp(19, 32'd1, "fetch_zlo");
    zlout = 1; pcin = 1; read = 1; mdrin = 1; mdat = 32'h2891_8000;
    tick();
    mdrout = 1; irin = 1;
    tick();
    check("fetch_ir", {32'b0, ir_q}, 64'h2891_8000);
    peek_exp(20, 32'd1, "fetch_pc");
    // ADD and arithmetic shift right.
    load_y(32'd5);
    alu_mdr(5'd0, 32'd7);
    peek_exp(19, 32'd12, "add_zlo");
    load_y(32'h8000_0000);
    alu_mdr(5'd7, 32'd4);
    peek_exp(19, 32'hF800_0000, "shra_zlo");
    // Shift/rotate by zero keep A; rotates by nonzero amounts.
    load_y(32'hA5C3_0F01);
    for (int op = 6; op <= 10; op++) begin
      alu_mdr(5'(op), 32'd32);
      peek_exp(19, 32'hA5C3_0F01, $sformatf("sh0_op%0d", op));
    end
    alu_mdr(5'd9, 32'd4);
    peek_exp(19, 32'h1A5C_30F0, "ror4");
    alu_mdr(5'd10, 32'd8);
    peek_exp(19, 32'hC30F_01A5, "rol8");
    // MUL / DIV.
    load_y(32'hFFFF_FFFD);
    alu_mdr(5'd11, 32'd4);
`ifdef DATAPATH_MULDIV_EN
    peek_exp(18, 32'hFFFF_FFFF, "mul_zhi");
    peek_exp(19, 32'hFFFF_FFF4, "mul_zlo");
`else
    peek_exp(18, 32'h0, "mul_zhi");
    peek_exp(19, 32'h0, "mul_zlo");
`endif
    load_y(32'd17);
    alu_mdr(5'd13, 32'd5);
`ifdef DATAPATH_MULDIV_EN
    peek_exp(19, 32'd3, "div_zlo");
    peek_exp(18, 32'd2, "div_zhi");
`else
    peek_exp(19, 32'd0, "div_zlo");
`endif
    alu_mdr(5'd13, 32'd0);
`ifdef DATAPATH_MULDIV_EN
    peek_exp(19, 32'hFFFF_FFFF, "div0_zlo");
    peek_exp(18, 32'd17, "div0_zhi");
`else
    peek_exp(18, 32'd0, "div0_zhi");
`endif
    alu_mdr(5'd20, 32'd9);
    peek_exp(19, 32'd0, "op20_zlo");
    // Bus priority and same-register drive/load.
    load_mdr(32'h2222_2222);
    mdrout = 1; rin[2] = 1;
    tick();
    load_mdr(32'h5555_5555);
    mdrout = 1; rin[5] = 1;
    tick();
    rout[2] = 1; rout[5] = 1;
    #1;
    check("prio_r2", {32'b0, bus_q}, 64'h2222_2222);
    clear_ctl();
    rout[1] = 1; rin[1] = 1;
    tick();
    peek_exp(1, 32'd57, "self_r1");
    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      rin = 16'($urandom & $urandom);
      rout = 16'($urandom & $urandom & $urandom);
      {pcin, irin, yin, marin, mdrin, hiin, loin, zin} = 8'($urandom);
      hiout = ($urandom_range(0, 5) == 0);
      loout = ($urandom_range(0, 5) == 0);
      zhout = ($urandom_range(0, 5) == 0);
      zlout = ($urandom_range(0, 5) == 0);
      pcout = ($urandom_range(0, 5) == 0);
      mdrout = ($urandom_range(0, 3) == 0);
      read = 1'($urandom);
      mdat = $urandom;
      opc = 5'($urandom_range(0, 17));
      if (opc == 5'd13 && m_y == 32'h8000_0000) opc = 5'd0;
      tick();
    end
    read_all();
    // Asynchronous clear mid-cycle with enables active.
    load_mdr(32'h0000_1234);
    mdrout = 1; marin = 1; irin = 1;
    tick();
    @(negedge clk);
    rin = '1; {pcin, irin, yin, marin, mdrin, hiin, loin, zin} = '1;
    read = 1; mdat = 32'hDEAD_BEEF; opc = 5'd12;
    #2;
    clr = 1;
    model_reset();
    #1;
    check("clr_mar", {32'b0, mar_q}, 64'd0);
    check("clr_ir", {32'b0, ir_q}, 64'd0);
    mdrout = 1;
    #1;
    check("clr_bus", {32'b0, bus_q}, 64'd0);
    @(posedge clk);
    #1;
    check("clrhold_mar", {32'b0, mar_q}, 64'd0);
    check("clrhold_ir", {32'b0, ir_q}, 64'd0);
    clear_ctl();
    read_all();
    @(negedge clk);
    clr = 0;
    load_mdr(32'h0BAD_F00D);
    mdrout = 1; marin = 1;
    tick();
    check("post_clr_mar", {32'b0, mar_q}, 64'h0BAD_F00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
